// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, redirect/stall
// handling, sticky misaligned-target flag and fetched-instruction counter.
module if_stage #(
  parameter logic [63:0] PC_RESET = 64'h0,
  parameter logic [31:0] NOP_INS  = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_ins,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_next;
  logic [63:0] pc, pc_next;
  logic [63:0] if_id_pc_next;
  logic [31:0] if_id_ins_next;
  logic        if_id_valid_next;
  logic        misalign_next;
  logic [31:0] fetch_count_next;

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= BOOT;
      pc           <= PC_RESET;
      if_id_pc     <= '0;
      if_id_ins    <= NOP_INS;
      if_id_valid  <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      if_id_pc     <= if_id_pc_next;
      if_id_ins    <= if_id_ins_next;
      if_id_valid  <= if_id_valid_next;
      misalign_err <= misalign_next;
      fetch_count  <= fetch_count_next;
    end
  end

  // Redirect outranks stall; the fetch enable is masked while reset is held.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    if_id_pc_next    = if_id_pc;
    if_id_ins_next   = if_id_ins;
    if_id_valid_next = if_id_valid;
    misalign_next    = misalign_err;
    fetch_count_next = fetch_count;
    imem_en          = 1'b0;
    unique case (state)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        imem_en = (!stall || branch_taken) && !reset;
        if (branch_taken) begin
          pc_next          = {branch_target[63:2], 2'b00};
          if_id_pc_next    = '0;
          if_id_ins_next   = NOP_INS;
          if_id_valid_next = 1'b0;
          misalign_next    = misalign_err | (branch_target[1:0] != 2'b00);
        end else if (!stall) begin
          pc_next          = pc + 64'd4;
          if_id_pc_next    = pc;
          if_id_ins_next   = imem_rdata;
          if_id_valid_next = 1'b1;
          fetch_count_next = fetch_count + 32'd1;
        end
      end
    endcase
  end

endmodule
